// File: rtl/eth_hdr_serializer_if.sv
// Header-plus-payload stream interface between frame generators and the Ethernet TX serializer.
interface eth_axis_interface;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    logic [7:0]  tdata;
    logic        tkeep;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;

    modport Sink (
        input  hdr_valid, dest_mac, src_mac, eth_type,
        input  tdata, tkeep, tvalid, tlast, tuser,
        output hdr_ready, tready
    );

    modport Source (
        output hdr_valid, dest_mac, src_mac, eth_type,
        output tdata, tkeep, tvalid, tlast, tuser,
        input  hdr_ready, tready
    );
endinterface

// File: rtl/eth_hdr_serializer.sv
// Serializes a 14-byte Ethernet header followed by the payload onto an 8-bit AXI-Stream.
// Define ETH_HDR_SER_PAD_EN to zero-pad short frames up to 60 bytes.
module eth_hdr_serializer (
    input  logic            clk,
    input  logic            rst_n,
    eth_axis_interface.Sink s_eth,
    output logic [7:0]      m_axis_tdata,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic            m_axis_tlast,
    output logic            m_axis_tuser,
    output logic            busy
);
    // state      | meaning
    // ST_IDLE    | waiting for a header handshake, hdr_ready high
    // ST_HEADER  | emitting header byte hdr_cnt_q (up to 13)
    // ST_PAYLOAD | forwarding upstream payload beats
    // ST_PAD     | emitting 0x00 until 60 frame bytes (pad build only)
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_PAD     = 2'd3
    } state_t;

    localparam logic [3:0] LAST_HDR_IDX = 4'd13;

    state_t       state_q, state_d;
    logic [111:0] hdr_q, hdr_d;
    logic [111:0] hdr_in;
    logic [3:0]   hdr_cnt_q, hdr_cnt_d;
    logic [7:0]   hdr_byte;
    logic [7:0]   tdata_q, tdata_d;
    logic         tvalid_q, tvalid_d;
    logic         tlast_q, tlast_d;
    logic         tuser_q, tuser_d;
    logic         busy_q, busy_d;
    logic         out_free;
    logic         hdr_ready_c;
    logic         tready_c;
    logic         unused_tkeep;

`ifdef ETH_HDR_SER_PAD_EN
    // Payload count 45 marks the 60th frame byte (14 header + 46).
    localparam logic [10:0] PAD_LAST_CNT = 11'd45;
    logic [10:0] pay_cnt_q, pay_cnt_d;
    logic        tuser_lat_q, tuser_lat_d;
`endif

    assign hdr_in       = {s_eth.dest_mac, s_eth.src_mac, s_eth.eth_type};
    assign hdr_byte     = hdr_q[7'd111 - {hdr_cnt_q, 3'b000} -: 8];
    assign out_free     = !tvalid_q || m_axis_tready;
    assign unused_tkeep = s_eth.tkeep;

    always_comb begin
        state_d     = state_q;
        hdr_d       = hdr_q;
        hdr_cnt_d   = hdr_cnt_q;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tuser_d     = tuser_q;
        busy_d      = busy_q;
        hdr_ready_c = 1'b0;
        tready_c    = 1'b0;
`ifdef ETH_HDR_SER_PAD_EN
        pay_cnt_d   = pay_cnt_q;
        tuser_lat_d = tuser_lat_q;
`endif

        // Drain first; a load below in the same cycle overrides it.
        if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
            if (tlast_q) begin
                busy_d = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                hdr_ready_c = 1'b1;
                if (s_eth.hdr_valid) begin
                    hdr_d     = hdr_in;
                    hdr_cnt_d = 4'd0;
                    busy_d    = 1'b1;
                    state_d   = ST_HEADER;
`ifdef ETH_HDR_SER_PAD_EN
                    pay_cnt_d = 11'd0;
`endif
                    // Byte 0 goes straight from the bus so it appears the next cycle.
                    if (out_free) begin
                        tdata_d   = hdr_in[111:104];
                        tvalid_d  = 1'b1;
                        tlast_d   = 1'b0;
                        tuser_d   = 1'b0;
                        hdr_cnt_d = 4'd1;
                    end
                end
            end

            ST_HEADER: begin
                if (out_free) begin
                    tdata_d   = hdr_byte;
                    tvalid_d  = 1'b1;
                    tlast_d   = 1'b0;
                    tuser_d   = 1'b0;
                    hdr_cnt_d = hdr_cnt_q + 4'd1;
                    if (hdr_cnt_q == LAST_HDR_IDX) begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end

            ST_PAYLOAD: begin
                tready_c = out_free;
                if (s_eth.tvalid && out_free) begin
                    tdata_d  = s_eth.tdata;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    tuser_d  = 1'b0;
`ifdef ETH_HDR_SER_PAD_EN
                    if (pay_cnt_q != 11'h7FF) begin
                        pay_cnt_d = pay_cnt_q + 11'd1;
                    end
                    if (s_eth.tlast) begin
                        if (pay_cnt_q < PAD_LAST_CNT) begin
                            tuser_lat_d = s_eth.tuser;
                            state_d     = ST_PAD;
                        end else begin
                            tlast_d = 1'b1;
                            tuser_d = s_eth.tuser;
                            state_d = ST_IDLE;
                        end
                    end
`else
                    if (s_eth.tlast) begin
                        tlast_d = 1'b1;
                        tuser_d = s_eth.tuser;
                        state_d = ST_IDLE;
                    end
`endif
                end
            end

`ifdef ETH_HDR_SER_PAD_EN
            ST_PAD: begin
                if (out_free) begin
                    tdata_d   = 8'h00;
                    tvalid_d  = 1'b1;
                    tlast_d   = 1'b0;
                    tuser_d   = 1'b0;
                    pay_cnt_d = pay_cnt_q + 11'd1;
                    if (pay_cnt_q == PAD_LAST_CNT) begin
                        tlast_d = 1'b1;
                        tuser_d = tuser_lat_q;
                        state_d = ST_IDLE;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hdr_q       <= '0;
            hdr_cnt_q   <= 4'd0;
            tdata_q     <= 8'h00;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef ETH_HDR_SER_PAD_EN
            pay_cnt_q   <= 11'd0;
            tuser_lat_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            hdr_cnt_q   <= hdr_cnt_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            busy_q      <= busy_d;
`ifdef ETH_HDR_SER_PAD_EN
            pay_cnt_q   <= pay_cnt_d;
            tuser_lat_q <= tuser_lat_d;
`endif
        end
    end

    assign s_eth.hdr_ready = hdr_ready_c;
    assign s_eth.tready    = tready_c;
    assign m_axis_tdata    = tdata_q;
    assign m_axis_tvalid   = tvalid_q;
    assign m_axis_tlast    = tlast_q;
    assign m_axis_tuser    = tuser_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_eth_hdr_serializer.sv
// Self-checking bench for eth_hdr_serializer: queue-based frame model, random stalls, reset mid-frame.
module tb_eth_hdr_serializer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;
    logic       m_axis_tuser;
    logic       busy;

    eth_axis_interface s_eth ();

    eth_hdr_serializer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_eth         (s_eth),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    bit rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
    end

    // Stimulus and reference model queues
    logic [111:0] hd_q[$];
    logic [7:0]   pl_d[$];
    bit           pl_l[$];
    bit           pl_u[$];
    logic [7:0]   exp_d[$];
    bit           exp_l[$];
    bit           exp_u[$];

    // Observed traffic
    logic [7:0]   got_d[$];
    bit           got_l[$];
    bit           got_u[$];
    int           got_c[$];
    int           in_last_c[$];
    int           hdr_acc_c[$];
    int           stall_err = 0;

    bit           prev_stall = 1'b0;
    logic [7:0]   prev_data;
    logic         prev_last, prev_user;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data ||
                               m_axis_tlast !== prev_last || m_axis_tuser !== prev_user))
                stall_err++;
            if (m_axis_tvalid && m_axis_tready) begin
                got_d.push_back(m_axis_tdata);
                got_l.push_back(m_axis_tlast);
                got_u.push_back(m_axis_tuser);
                got_c.push_back(cyc);
            end
            if (s_eth.tvalid && s_eth.tready && s_eth.tlast) in_last_c.push_back(cyc);
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            prev_user  = m_axis_tuser;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_all();
        hd_q.delete(); pl_d.delete(); pl_l.delete(); pl_u.delete();
        exp_d.delete(); exp_l.delete(); exp_u.delete();
        got_d.delete(); got_l.delete(); got_u.delete(); got_c.delete();
        in_last_c.delete(); hdr_acc_c.delete();
        stall_err = 0;
    endtask

    // mode 0: random bytes, 1: 0x10 upward, 2: constant 0xEE
    task automatic add_frame(input logic [47:0] dest, input logic [47:0] src,
                             input logic [15:0] typ, input int len, input int mode,
                             input bit user);
        logic [7:0] bytes[$];
        logic [7:0] b;
        hd_q.push_back({dest, src, typ});
        for (int i = 0; i < 6; i++) bytes.push_back(8'(dest >> (8 * (5 - i))));
        for (int i = 0; i < 6; i++) bytes.push_back(8'(src >> (8 * (5 - i))));
        bytes.push_back(8'(typ >> 8));
        bytes.push_back(8'(typ));
        for (int i = 0; i < len; i++) begin
            b = (mode == 0) ? 8'($urandom) : (mode == 1) ? 8'(16 + i) : 8'hEE;
            pl_d.push_back(b);
            pl_l.push_back(i == len - 1);
            pl_u.push_back((i == len - 1) ? user : 1'($urandom_range(0, 1)));
            bytes.push_back(b);
        end
`ifdef ETH_HDR_SER_PAD_EN
        while (bytes.size() < 60) bytes.push_back(8'h00);
`endif
        for (int k = 0; k < bytes.size(); k++) begin
            exp_d.push_back(bytes[k]);
            exp_l.push_back(k == bytes.size() - 1);
            exp_u.push_back((k == bytes.size() - 1) && user);
        end
    endtask

    task automatic run_frames(input bit rand_valid);
        int t;
        fork
            begin : hdr_drv
                int th;
                for (int h = 0; h < hd_q.size(); h++) begin
                    @(posedge clk); #1;
                    s_eth.hdr_valid = 1'b1;
                    {s_eth.dest_mac, s_eth.src_mac, s_eth.eth_type} = hd_q[h];
                    th = 0;
                    forever begin
                        @(negedge clk);
                        if (s_eth.hdr_ready) begin
                            hdr_acc_c.push_back(cyc);
                            break;
                        end
                        th++;
                        if (th > 3000) break;
                        @(posedge clk); #1;
                    end
                end
                @(posedge clk); #1;
                s_eth.hdr_valid = 1'b0;
            end
            begin : pl_drv
                int i, guard;
                i = 0;
                guard = 0;
                while (i < pl_d.size() && guard < 6000) begin
                    @(posedge clk); #1;
                    s_eth.tvalid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
                    s_eth.tdata  = pl_d[i];
                    s_eth.tlast  = pl_l[i];
                    s_eth.tuser  = pl_u[i];
                    @(negedge clk);
                    if (s_eth.tvalid && s_eth.tready) i++;
                    guard++;
                end
                @(posedge clk); #1;
                s_eth.tvalid = 1'b0;
                s_eth.tlast  = 1'b0;
                s_eth.tuser  = 1'b0;
            end
        join
        t = 0;
        while (got_d.size() < exp_d.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (got_d.size() != exp_d.size()) begin
            n_fails++;
            $display("FAIL byte_count: observed %0d bytes, expected %0d", got_d.size(), exp_d.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_axis_tready = 1'b0;
        s_eth.hdr_valid = 1'b0; s_eth.dest_mac = '0; s_eth.src_mac = '0; s_eth.eth_type = '0;
        s_eth.tdata = '0; s_eth.tkeep = 1'b1; s_eth.tvalid = 1'b0; s_eth.tlast = 1'b0; s_eth.tuser = 1'b0;
        repeat (3) @(negedge clk);
        n_checks += 7;
        if (m_axis_tvalid !== 1'b0) begin n_fails++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        if (m_axis_tdata !== 8'h00) begin n_fails++; $display("FAIL reset_tdata: got %h want 00", m_axis_tdata); end
        if (m_axis_tlast !== 1'b0) begin n_fails++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        if (m_axis_tuser !== 1'b0) begin n_fails++; $display("FAIL reset_tuser: got %b want 0", m_axis_tuser); end
        if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (s_eth.hdr_ready !== 1'b1) begin n_fails++; $display("FAIL reset_hdr_ready: got %b want 1", s_eth.hdr_ready); end
        if (s_eth.tready !== 1'b0) begin n_fails++; $display("FAIL reset_tready: got %b want 0", s_eth.tready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        int acc;
        clear_all();
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;
        add_frame(48'h0102_0304_0506, 48'hA1A2_A3A4_A5A6, 16'h0800, 64, 1, 1'b0);
        run_frames(1'b0);
        for (int k = 0; k < exp_d.size(); k++) begin
            logic [9:0] got;
            got = (k < got_d.size()) ? {got_d[k], got_l[k], got_u[k]} : 10'bx;
            n_checks++;
            if (got !== {exp_d[k], exp_l[k], exp_u[k]}) begin
                n_fails++;
                $display("FAIL single_byte[%0d]: got data/last/user %h, want %h", k, got,
                         {exp_d[k], exp_l[k], exp_u[k]});
            end
        end
        acc = (hdr_acc_c.size() > 0) ? hdr_acc_c[0] : -100;
        n_checks += 3;
        if ((got_c.size() > 0 ? got_c[0] : -1) != acc + 1) begin
            n_fails++; $display("FAIL single_byte0_latency: got cycle %0d, want %0d", got_c.size() > 0 ? got_c[0] : -1, acc + 1);
        end
        if ((got_c.size() > 77 ? got_c[77] : -1) != acc + 78) begin
            n_fails++; $display("FAIL single_no_bubble: last byte cycle %0d, want %0d", got_c.size() > 77 ? got_c[77] : -1, acc + 78);
        end
        if (busy !== 1'b0) begin n_fails++; $display("FAIL single_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_random_stall();
        clear_all();
        rand_ready = 1'b1;
        add_frame(48'($urandom) << 16 | 48'($urandom), 48'h0BAD_CAFE_0001, 16'h86DD, 100, 0, 1'b0);
        run_frames(1'b1);
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;
        for (int k = 0; k < exp_d.size(); k++) begin
            logic [9:0] got;
            got = (k < got_d.size()) ? {got_d[k], got_l[k], got_u[k]} : 10'bx;
            n_checks++;
            if (got !== {exp_d[k], exp_l[k], exp_u[k]}) begin
                n_fails++;
                $display("FAIL stall_byte[%0d]: got %h, want %h", k, got, {exp_d[k], exp_l[k], exp_u[k]});
            end
        end
        n_checks++;
        if (stall_err != 0) begin n_fails++; $display("FAIL stall_hold: %0d unstable stalled cycles, want 0", stall_err); end
    endtask

    task automatic test_tuser();
        clear_all();
        rand_ready = 1'b1;
        add_frame(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0806, 47, 0, 1'b1);
        add_frame(48'h3333_0000_0001, 48'h0200_0000_0002, 16'h0800, 5, 0, 1'b1);
        run_frames(1'b1);
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;
        for (int k = 0; k < exp_d.size(); k++) begin
            logic [9:0] got;
            got = (k < got_d.size()) ? {got_d[k], got_l[k], got_u[k]} : 10'bx;
            n_checks++;
            if (got !== {exp_d[k], exp_l[k], exp_u[k]}) begin
                n_fails++;
                $display("FAIL tuser_byte[%0d]: got %h, want %h", k, got, {exp_d[k], exp_l[k], exp_u[k]});
            end
        end
    endtask

    task automatic test_back_to_back();
        int f1_last;
        int acc2, tl1, c_last, c_next;
        clear_all();
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;
        add_frame(48'h0011_2233_4455, 48'h6677_8899_AABB, 16'h0800, 50, 0, 1'b0);
        add_frame(48'hCCDD_EEFF_0011, 48'h2233_4455_6677, 16'h88B5, 48, 0, 1'b1);
        run_frames(1'b0);
        for (int k = 0; k < exp_d.size(); k++) begin
            logic [9:0] got;
            got = (k < got_d.size()) ? {got_d[k], got_l[k], got_u[k]} : 10'bx;
            n_checks++;
            if (got !== {exp_d[k], exp_l[k], exp_u[k]}) begin
                n_fails++;
                $display("FAIL b2b_byte[%0d]: got %h, want %h", k, got, {exp_d[k], exp_l[k], exp_u[k]});
            end
        end
        f1_last = 0;
        while (f1_last < exp_l.size() - 1 && !exp_l[f1_last]) f1_last++;
        acc2   = (hdr_acc_c.size() > 1) ? hdr_acc_c[1] : -1;
        tl1    = (in_last_c.size() > 0) ? in_last_c[0] : -100;
        c_last = (got_c.size() > f1_last) ? got_c[f1_last] : -100;
        c_next = (got_c.size() > f1_last + 1) ? got_c[f1_last + 1] : -1;
        n_checks += 2;
        if (acc2 != tl1 + 1) begin
            n_fails++; $display("FAIL b2b_hdr_accept: second header accepted cycle %0d, want %0d", acc2, tl1 + 1);
        end
        if (c_next != c_last + 1) begin
            n_fails++; $display("FAIL b2b_gap: frame2 byte0 cycle %0d, want %0d", c_next, c_last + 1);
        end
    endtask

    task automatic test_pad();
        int want_len;
`ifdef ETH_HDR_SER_PAD_EN
        want_len = 60;
`else
        want_len = 24;
`endif
        clear_all();
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;
        add_frame(48'h0102_0304_0506, 48'hA1A2_A3A4_A5A6, 16'h0800, 10, 2, 1'b1);
        run_frames(1'b0);
        n_checks++;
        if (got_d.size() != want_len) begin
            n_fails++; $display("FAIL pad_length: got %0d bytes, want %0d", got_d.size(), want_len);
        end
        for (int k = 0; k < exp_d.size(); k++) begin
            logic [9:0] got;
            got = (k < got_d.size()) ? {got_d[k], got_l[k], got_u[k]} : 10'bx;
            n_checks++;
            if (got !== {exp_d[k], exp_l[k], exp_u[k]}) begin
                n_fails++;
                $display("FAIL pad_byte[%0d]: got %h, want %h", k, got, {exp_d[k], exp_l[k], exp_u[k]});
            end
        end
    endtask

    task automatic test_reset_midframe();
        clear_all();
        rand_ready = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge clk); #1;
        s_eth.hdr_valid = 1'b1;
        s_eth.dest_mac  = 48'h1122_3344_5566;
        s_eth.src_mac   = 48'h7788_99AA_BBCC;
        s_eth.eth_type  = 16'h0800;
        @(negedge clk);
        @(posedge clk); #1;
        s_eth.hdr_valid = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (busy !== 1'b1) begin n_fails++; $display("FAIL midrst_busy_rise: got %b want 1", busy); end
        if (m_axis_tdata !== 8'h11) begin n_fails++; $display("FAIL midrst_byte0: got %h want 11", m_axis_tdata); end
        repeat (7) @(negedge clk);
        n_checks++;
        if (m_axis_tdata !== 8'h88) begin n_fails++; $display("FAIL midrst_byte7: got %h want 88", m_axis_tdata); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks += 5;
        if (m_axis_tvalid !== 1'b0) begin n_fails++; $display("FAIL midrst_tvalid: got %b want 0", m_axis_tvalid); end
        if (m_axis_tdata !== 8'h00) begin n_fails++; $display("FAIL midrst_tdata: got %h want 00", m_axis_tdata); end
        if (m_axis_tlast !== 1'b0) begin n_fails++; $display("FAIL midrst_tlast: got %b want 0", m_axis_tlast); end
        if (m_axis_tuser !== 1'b0) begin n_fails++; $display("FAIL midrst_tuser: got %b want 0", m_axis_tuser); end
        if (busy !== 1'b0) begin n_fails++; $display("FAIL midrst_busy: got %b want 0", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (s_eth.hdr_ready !== 1'b1) begin n_fails++; $display("FAIL midrst_hdr_ready: got %b want 1", s_eth.hdr_ready); end
        if (m_axis_tvalid !== 1'b0) begin n_fails++; $display("FAIL midrst_no_tail: got %b want 0", m_axis_tvalid); end
        clear_all();
        add_frame(48'hDEAD_BEEF_0001, 48'h0000_0000_00FE, 16'h0801, 52, 0, 1'b0);
        run_frames(1'b0);
        for (int k = 0; k < exp_d.size(); k++) begin
            logic [9:0] got;
            got = (k < got_d.size()) ? {got_d[k], got_l[k], got_u[k]} : 10'bx;
            n_checks++;
            if (got !== {exp_d[k], exp_l[k], exp_u[k]}) begin
                n_fails++;
                $display("FAIL midrst_next_byte[%0d]: got %h, want %h", k, got, {exp_d[k], exp_l[k], exp_u[k]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_random_stall();
        test_tuser();
        test_back_to_back();
        test_pad();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
